// File: rtl/dma_utils_pkg.sv
// rtl/dma_utils_pkg.sv - shared AXI4 types, encodings and address helpers for the DMA memory path
package dma_utils_pkg;
    localparam int AXI_ADDR_W    = 32;
    localparam int AXI_DATA_W    = 32;
    localparam int AXI_STRB_W    = AXI_DATA_W / 8;
    localparam int AXI_ID_W      = 4;
    localparam int AXI_BUS_BYTES = AXI_STRB_W;

    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [AXI_STRB_W-1:0] axi_strb_t;
    typedef logic [AXI_ID_W-1:0]   axi_tid_t;
    typedef logic [7:0]            axi_alen_t;
    typedef logic [2:0]            axi_size_t;
    typedef logic [1:0]            axi_burst_t;
    typedef logic [1:0]            axi_error_t;

    localparam axi_size_t  AXI_BUS_SIZE    = 3'd2;
    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;
    localparam axi_error_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_error_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_error_t AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

    typedef struct packed {
        axi_tid_t   awid;
        axi_addr_t  awaddr;
        axi_alen_t  awlen;
        axi_size_t  awsize;
        axi_burst_t awburst;
        logic       awvalid;
        axi_data_t  wdata;
        axi_strb_t  wstrb;
        logic       wlast;
        logic       wvalid;
        logic       bready;
        axi_tid_t   arid;
        axi_addr_t  araddr;
        axi_alen_t  arlen;
        axi_size_t  arsize;
        axi_burst_t arburst;
        logic       arvalid;
        logic       rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        axi_tid_t   bid;
        axi_error_t bresp;
        logic       bvalid;
        logic       arready;
        axi_tid_t   rid;
        axi_data_t  rdata;
        axi_error_t rresp;
        logic       rlast;
        logic       rvalid;
    } s_axi_miso_t;

    // Non-INCR bursts hold the address; WRAP is flagged as an error elsewhere.
    function automatic axi_addr_t axi_next_addr(axi_addr_t addr, axi_size_t size, axi_burst_t burst);
        axi_addr_t step;
        step = axi_addr_t'(1) << size;
        if (burst == AXI_BURST_INCR)
            return (addr & ~(step - axi_addr_t'(1))) + step;
        return addr;
    endfunction

    // Encodings are ordered so the numerically larger response is the worse one.
    function automatic axi_error_t axi_worst_resp(axi_error_t a, axi_error_t b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi_mem_slave_if.sv
// rtl/axi_mem_slave_if.sv - AXI4 request/response bundle between DMA master and memory responder
interface axi_mem_slave_if;
    import dma_utils_pkg::*;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;
    modport master (output mosi, input miso);
    modport slave  (input mosi, output miso);
endinterface

// File: rtl/axi_mem_slave_addr_gen.sv
// rtl/axi_mem_slave_addr_gen.sv - per-channel burst address, beat counter and per-beat error decode
module axi_slave_addr_gen
    import dma_utils_pkg::*;
#(
    parameter int        MEM_WORDS = 1024,
    parameter axi_addr_t BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  axi_addr_t                    i_addr,
    input  axi_alen_t                    i_len,
    input  axi_size_t                    i_size,
    input  axi_burst_t                   i_burst,
    input  logic                         i_advance,
    output logic [$clog2(MEM_WORDS)-1:0] o_word_idx,
    output logic                         o_last,
    output axi_error_t                   o_err
);
    localparam axi_addr_t MEM_BYTES = axi_addr_t'(MEM_WORDS * AXI_BUS_BYTES);

    axi_addr_t          r_addr;
    axi_alen_t          r_len;
    axi_alen_t          r_count;
    axi_size_t          r_size;
    axi_burst_t         r_burst;
    axi_addr_t          w_addr;
    axi_alen_t          w_len;
    axi_alen_t          w_count;
    axi_size_t          w_size;
    axi_burst_t         w_burst;
    logic [AXI_ADDR_W:0] w_offset;

    // A load is visible in the same cycle so a zero-latency read can fetch on the AR edge.
    always_comb begin
        w_addr  = i_load ? i_addr  : r_addr;
        w_len   = i_load ? i_len   : r_len;
        w_size  = i_load ? i_size  : r_size;
        w_burst = i_load ? i_burst : r_burst;
        w_count = i_load ? '0      : r_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else if (i_load || i_advance) begin
            r_addr  <= i_advance ? axi_next_addr(w_addr, w_size, w_burst) : w_addr;
            r_len   <= w_len;
            r_size  <= w_size;
            r_burst <= w_burst;
            r_count <= w_count + axi_alen_t'(i_advance);
        end
    end

    assign w_offset   = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign o_word_idx = w_offset[$clog2(MEM_WORDS)+1:2];
    assign o_last     = (w_count == w_len);

    always_comb begin
        o_err = AXI_RESP_OKAY;
        if (w_offset[AXI_ADDR_W] || (w_offset[AXI_ADDR_W-1:0] >= MEM_BYTES))
            o_err = AXI_RESP_DECERR;
        else if ((w_size > AXI_BUS_SIZE) ||
                 ((w_burst != AXI_BURST_FIXED) && (w_burst != AXI_BURST_INCR)))
            o_err = AXI_RESP_SLVERR;
    end
endmodule

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 memory responder with independent single-outstanding read and write channels
module axi_mem_slave
    import dma_utils_pkg::*;
#(
    parameter int        MEM_WORDS    = 1024,
    parameter axi_addr_t BASE_ADDR    = '0,
    parameter int        READ_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    axi_mem_slave_if.slave axi_if
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    axi_data_t        r_mem [MEM_WORDS];
    wr_state_t        r_wr_state;
    wr_state_t        w_wr_next;
    rd_state_t        r_rd_state;
    rd_state_t        w_rd_next;
    logic             r_awready;
    logic             r_arready;
    axi_tid_t         r_awid;
    axi_tid_t         r_arid;
    axi_error_t       r_bresp;
    axi_error_t       r_rresp;
    axi_data_t        r_rdata;
    logic             r_rlast;
    logic [3:0]       r_lat_cnt;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_ar_hs;
    logic             w_rd_fetch;
    logic             w_lat_done;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_wr_last;
    logic             w_rd_last;
    axi_error_t       w_wr_err;
    axi_error_t       w_rd_err;
    axi_error_t       w_wbeat_resp;

    assign w_aw_hs    = (r_wr_state == WR_IDLE) && axi_if.mosi.awvalid && r_awready;
    assign w_w_hs     = (r_wr_state == WR_DATA) && axi_if.mosi.wvalid;
    assign w_ar_hs    = (r_rd_state == RD_IDLE) && axi_if.mosi.arvalid && r_arready;
    assign w_lat_done = (r_lat_cnt == 4'(READ_LATENCY - 1));

    axi_slave_addr_gen #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) u_wr_addr (
        .clk(clk), .rst(rst), .i_load(w_aw_hs),
        .i_addr(axi_if.mosi.awaddr), .i_len(axi_if.mosi.awlen),
        .i_size(axi_if.mosi.awsize), .i_burst(axi_if.mosi.awburst),
        .i_advance(w_w_hs), .o_word_idx(w_wr_idx), .o_last(w_wr_last), .o_err(w_wr_err)
    );

    axi_slave_addr_gen #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) u_rd_addr (
        .clk(clk), .rst(rst), .i_load(w_ar_hs),
        .i_addr(axi_if.mosi.araddr), .i_len(axi_if.mosi.arlen),
        .i_size(axi_if.mosi.arsize), .i_burst(axi_if.mosi.arburst),
        .i_advance(w_rd_fetch), .o_word_idx(w_rd_idx), .o_last(w_rd_last), .o_err(w_rd_err)
    );

    // Burst length is governed by awlen; a misplaced wlast only degrades the response.
    assign w_wbeat_resp = axi_worst_resp(w_wr_err,
        (axi_if.mosi.wlast != w_wr_last) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (w_aw_hs) w_wr_next = WR_DATA;
            WR_DATA: if (w_w_hs && w_wr_last) w_wr_next = WR_RESP;
            WR_RESP: if (axi_if.mosi.bready) w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b0;
            r_awid     <= '0;
            r_bresp    <= AXI_RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            r_awready  <= (w_wr_next == WR_IDLE);
            if (w_aw_hs) begin
                r_awid  <= axi_if.mosi.awid;
                r_bresp <= AXI_RESP_OKAY;
            end else if (w_w_hs) begin
                r_bresp <= axi_worst_resp(r_bresp, w_wbeat_resp);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs && (w_wr_err == AXI_RESP_OKAY)) begin
            for (int b = 0; b < AXI_STRB_W; b++)
                if (axi_if.mosi.wstrb[b])
                    r_mem[w_wr_idx][8*b +: 8] <= axi_if.mosi.wdata[8*b +: 8];
        end
    end

    // A fetch loads the R output registers; the next beat is fetched on each non-final handshake.
    always_comb begin
        w_rd_next  = r_rd_state;
        w_rd_fetch = 1'b0;
        case (r_rd_state)
            RD_IDLE: if (w_ar_hs) begin
                if (READ_LATENCY == 0) begin
                    w_rd_next  = RD_DATA;
                    w_rd_fetch = 1'b1;
                end else begin
                    w_rd_next = RD_WAIT;
                end
            end
            RD_WAIT: if (w_lat_done) begin
                w_rd_next  = RD_DATA;
                w_rd_fetch = 1'b1;
            end
            RD_DATA: if (axi_if.mosi.rready) begin
                if (r_rlast) w_rd_next  = RD_IDLE;
                else         w_rd_fetch = 1'b1;
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_arid     <= '0;
            r_lat_cnt  <= '0;
            r_rdata    <= '0;
            r_rresp    <= AXI_RESP_OKAY;
            r_rlast    <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            r_arready  <= (w_rd_next == RD_IDLE);
            if (w_ar_hs) begin
                r_arid    <= axi_if.mosi.arid;
                r_lat_cnt <= '0;
            end else if (r_rd_state == RD_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 4'd1;
            end
            if (w_rd_fetch) begin
                r_rdata <= (w_rd_err == AXI_RESP_OKAY) ? r_mem[w_rd_idx] : '0;
                r_rresp <= w_rd_err;
                r_rlast <= w_rd_last;
            end
        end
    end

    always_comb begin
        axi_if.miso         = '0;
        axi_if.miso.awready = r_awready;
        axi_if.miso.wready  = (r_wr_state == WR_DATA);
        axi_if.miso.bvalid  = (r_wr_state == WR_RESP);
        axi_if.miso.bid     = r_awid;
        axi_if.miso.bresp   = r_bresp;
        axi_if.miso.arready = r_arready;
        axi_if.miso.rvalid  = (r_rd_state == RD_DATA);
        axi_if.miso.rid     = r_arid;
        axi_if.miso.rdata   = r_rdata;
        axi_if.miso.rresp   = r_rresp;
        axi_if.miso.rlast   = r_rlast;
    end
endmodule
